sub_layer_serial: RTL and testbench



---
 rtl/sub_layer_serial_pkg.sv | 6 +
 rtl/sub_layer_serial_sbox.sv | 9 +
 rtl/sub_layer_serial.sv | 67 ++++++
 tb/tb_sub_layer_serial.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sub_layer_serial_pkg.sv
// sub_layer_serial_pkg: shared widths and FSM encoding for the serialized uLBC-128 substitution layer.
package sub_layer_serial_pkg;
  localparam int STATE_W = 128;
  localparam int NIB_COUNT = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
endpackage

// File: rtl/sub_layer_serial_sbox.sv
// sub_layer_serial_sbox: 4-bit uLBC S-box.
module sub_layer_serial_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Entry k lives at bits [4k+3:4k].
  localparam logic [63:0] LUT = 64'h7563_4DC9_12EF_0A8B;
  assign dout = LUT[{din, 2'b00} +: 4];
endmodule

// File: rtl/sub_layer_serial.sv
// sub_layer_serial: substitutes all 32 nibbles of a 128-bit state, NIB_PER_CYC nibbles per clock, LSB group first.
module sub_layer_serial
  import sub_layer_serial_pkg::*;
#(
  parameter int NIB_PER_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);
  localparam int N = NIB_COUNT / NIB_PER_CYC;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int GW = 4 * NIB_PER_CYC;
  fsm_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [GW-1:0] grp, sub;
  logic last;
  assign grp = st_q[int'(cnt_q) * GW +: GW];
  assign last = cnt_q == CW'(N - 1);
  genvar i;
  generate
    for (i = 0; i < NIB_PER_CYC; i++) begin : g_sbox
      sub_layer_serial_sbox u_sbox (.din(grp[4*i +: 4]), .dout(sub[4*i +: 4]));
    end
  endgenerate
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    st_d = st_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d = '0;
        st_d = in_state;
      end
      RUN: begin
        st_d[int'(cnt_q) * GW +: GW] = sub;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_state = st_q;
endmodule

// File: tb/tb_sub_layer_serial.sv
// tb_sub_layer_serial: checks three widths (1, 4, 32 nibbles/clk) against a nibble-wise S-box model.
module tb_sub_layer_serial;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [127:0] in_state = '0;
  logic [2:0] rdy, vld, bsy;
  logic [127:0] os [3];
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sub_layer_serial #(.NIB_PER_CYC(1)) dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_state(in_state), .out_valid(vld[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0]));
  sub_layer_serial #(.NIB_PER_CYC(4)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_state(in_state), .out_valid(vld[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1]));
  sub_layer_serial #(.NIB_PER_CYC(32)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_state(in_state), .out_valid(vld[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2]));

  function automatic int npc(int d);
    return d == 0 ? 1 : d == 1 ? 4 : 32;
  endfunction

  function automatic logic [127:0] sub_ref(logic [127:0] s);
    logic [3:0] t [16] = '{4'hB, 4'h8, 4'hA, 4'h0, 4'hF, 4'hE, 4'h2, 4'h1,
                           4'h9, 4'hC, 4'hD, 4'h4, 4'h3, 4'h6, 4'h5, 4'h7};
    logic [127:0] r;
    for (int k = 0; k < 32; k++) r[4*k +: 4] = t[s[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept s on all three instances, measure latency, hold DONE for `hold` cycles, then hand off.
  task automatic run3(input logic [127:0] s, input int hold);
    int lat[3];
    int e;
    logic [127:0] exp;
    exp = sub_ref(s);
    lat = '{0, 0, 0};
    e = 0;
    in_state = s;
    in_valid = 1;
    out_ready = 0;
    do begin
      step();
      e++;
      in_valid = 0;
      in_state = rnd128();
      for (int d = 0; d < 3; d++) if (vld[d] && lat[d] == 0) lat[d] = e;
    end while (vld != 3'b111 && e < 100);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("latency_npc%0d", npc(d)), 128'(lat[d]), 128'(32 / npc(d) + 1));
      chk($sformatf("result_npc%0d", npc(d)), os[d], exp);
      chk($sformatf("busy_done_npc%0d", npc(d)), 128'(bsy[d]), 128'(1));
    end
    repeat (hold) begin
      step();
      chk("hold_valid", 128'(vld), 128'(3'b111));
      chk("hold_state", os[0], exp);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("handoff_valid", 128'(vld), 128'(0));
    chk("handoff_ready", 128'(rdy), 128'(3'b111));
    chk("handoff_busy", 128'(bsy), 128'(0));
  endtask

  initial begin
    logic [127:0] q [3][$];
    int last_acc[3];
    int cyc;
    logic [127:0] v;
    v = 128'h0123456789ABCDEF0123456789ABCDEF;
    #12;
    chk("reset_ready", 128'(rdy), 128'(3'b111));
    chk("reset_valid", 128'(vld), 128'(0));
    chk("reset_busy", 128'(bsy), 128'(0));
    chk("reset_state", os[2], 128'(0));
    rst_n = 1;
    step();
    chk("post_reset_ready", 128'(rdy), 128'(3'b111));

    run3('0, 0);
    chk("zero_const", os[0], {32{4'hB}});
    run3(v, 0);
    chk("vector_const", os[1], 128'hB8A0FE219CD43657B8A0FE219CD43657);
    run3({32{4'hF}}, 10);
    chk("allf_const", os[0], {32{4'h7}});

    // Back-to-back with in_state randomized every cycle.
    in_valid = 1;
    out_ready = 1;
    last_acc = '{-1, -1, -1};
    cyc = 0;
    while (cyc < 400 || ((q[0].size() + q[1].size() + q[2].size()) != 0 && cyc < 600)) begin
      in_state = rnd128();
      if (cyc >= 400) in_valid = 0;
      for (int d = 0; d < 3; d++) begin
        if (rdy[d] && in_valid) begin
          if (last_acc[d] >= 0) chk($sformatf("spacing_npc%0d", npc(d)), 128'(cyc - last_acc[d]), 128'(32 / npc(d) + 2));
          last_acc[d] = cyc;
          q[d].push_back(sub_ref(in_state));
        end
        if (vld[d] && out_ready) begin
          if (q[d].size() == 0) chk($sformatf("spurious_npc%0d", npc(d)), 128'(1), 128'(0));
          else chk($sformatf("b2b_npc%0d", npc(d)), os[d], q[d].pop_front());
        end
      end
      step();
      cyc++;
    end
    chk("drain", 128'(q[0].size() + q[1].size() + q[2].size()), 128'(0));
    in_valid = 0;
    out_ready = 0;
    repeat (3) step();

    // Abort dut0 with its counter at 17.
    in_state = rnd128();
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (17) step();
    chk("mid_run_busy", 128'(bsy[0]), 128'(1));
    rst_n = 0;
    #1;
    chk("abort_valid", 128'(vld), 128'(0));
    chk("abort_state", os[0], 128'(0));
    chk("abort_ready", 128'(rdy), 128'(3'b111));
    step();
    rst_n = 1;
    step();
    run3(rnd128(), 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
